// File: rtl/hazard_scoreboard_if.sv
// Bundle of decode-side issue, writeback and ID-operand signals around the hazard scoreboard.
// The master drives the pipeline side. The slave is the scoreboard itself.
interface hazard_scoreboard_if #(
    parameter int LAT_W = 3
);
    logic             flush_all;
    logic             freeze;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic             issue_reg_write;
    logic [LAT_W-1:0] issue_lat;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [4:0]       rs1_addr_id;
    logic             rs1_used;
    logic [4:0]       rs2_addr_id;
    logic             rs2_used;
    logic [4:0]       rd_addr_id;
    logic             rd_write_id;
    logic             stall_id;
    logic             rs1_pending;
    logic             rs2_pending;
    logic [31:0]      busy_vec;

    modport master (
        output flush_all, freeze, issue_valid, issue_rd, issue_reg_write, issue_lat,
               wb_valid, wb_rd, rs1_addr_id, rs1_used, rs2_addr_id, rs2_used,
               rd_addr_id, rd_write_id,
        input  stall_id, rs1_pending, rs2_pending, busy_vec
    );

    modport slave (
        input  flush_all, freeze, issue_valid, issue_rd, issue_reg_write, issue_lat,
               wb_valid, wb_rd, rs1_addr_id, rs1_used, rs2_addr_id, rs2_used,
               rd_addr_id, rd_write_id,
        output stall_id, rs1_pending, rs2_pending, busy_vec
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes and their forwarding latency.
// From that state it raises stall_id for ID operands the forwarding path cannot supply yet.
module hazard_scoreboard #(
    parameter int LAT_W = 3,
    parameter int OUT_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave sb
);
    localparam logic [OUT_W-1:0] MAX_OUT = '1;
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
    localparam logic [LAT_W-1:0] CNT_ONE = LAT_W'(1);

    logic [OUT_W-1:0] out_q [32];
    logic [OUT_W-1:0] out_d [32];
    logic [LAT_W-1:0] cnt_q [32];
    logic [LAT_W-1:0] cnt_d [32];
    logic [31:0]      busy_q;
    logic [31:0]      busy_d;
    logic [31:0]      iss_vec;
    logic [31:0]      wb_vec;
    logic             rd_full;

    assign iss_vec = (sb.issue_valid && sb.issue_reg_write) ? (32'd1 << sb.issue_rd) : 32'd0;
    assign wb_vec  = sb.wb_valid ? (32'd1 << sb.wb_rd) : 32'd0;

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            out_d[r] = out_q[r];
            cnt_d[r] = cnt_q[r];
            if (sb.flush_all || r == 0) begin
                out_d[r] = '0;
                cnt_d[r] = '0;
            end else begin
                if (cnt_q[r] != '0 && !sb.freeze) begin
                    cnt_d[r] = cnt_q[r] - CNT_ONE;
                end
                // The youngest writer sets readiness; a same-cycle wb cancels its increment.
                if (iss_vec[r]) begin
                    cnt_d[r] = sb.issue_lat;
                    if (!(wb_vec[r] && out_q[r] != '0)) begin
                        out_d[r] = out_q[r] + OUT_ONE;
                    end
                end else if (wb_vec[r] && out_q[r] != '0) begin
                    out_d[r] = out_q[r] - OUT_ONE;
                    if (out_q[r] == OUT_ONE) begin
                        cnt_d[r] = '0;
                    end
                end
            end
            busy_d[r] = (out_d[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                out_q[r] <= '0;
                cnt_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                out_q[r] <= out_d[r];
                cnt_q[r] <= cnt_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign sb.rs1_pending = sb.rs1_used && (sb.rs1_addr_id != 5'd0) &&
                            (out_q[sb.rs1_addr_id] != '0) && (cnt_q[sb.rs1_addr_id] != '0);
    assign sb.rs2_pending = sb.rs2_used && (sb.rs2_addr_id != 5'd0) &&
                            (out_q[sb.rs2_addr_id] != '0) && (cnt_q[sb.rs2_addr_id] != '0);
    assign rd_full        = sb.rd_write_id && (sb.rd_addr_id != 5'd0) &&
                            (out_q[sb.rd_addr_id] == MAX_OUT);
    assign sb.stall_id    = sb.rs1_pending || sb.rs2_pending || rd_full;
    assign sb.busy_vec    = busy_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus randomized traffic checked against a per-register count/countdown model.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.LAT_W(3)) sb_if ();
    hazard_scoreboard #(.LAT_W(3), .OUT_W(2)) dut (.clk(clk), .rst(rst), .sb(sb_if));

    int checks = 0;
    int failures = 0;
    int mo [32];
    int mc [32];

    function automatic logic m_pend(input logic [4:0] a, input logic used);
        return used && a != 5'd0 && mo[a] > 0 && mc[a] > 0;
    endfunction

    function automatic logic m_stall();
        return m_pend(sb_if.rs1_addr_id, sb_if.rs1_used) || m_pend(sb_if.rs2_addr_id, sb_if.rs2_used)
            || (sb_if.rd_write_id && sb_if.rd_addr_id != 5'd0 && mo[sb_if.rd_addr_id] == 3);
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        for (int r = 0; r < 32; r++) b[r] = (mo[r] > 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            mo[r] = 0;
            mc[r] = 0;
        end
    endtask

    task automatic model_edge();
        bit iss, wbh;
        int ird, wrd;
        if (sb_if.flush_all) begin
            model_reset();
            return;
        end
        for (int r = 1; r < 32; r++)
            if (mc[r] > 0 && !sb_if.freeze) mc[r] = mc[r] - 1;
        ird = int'(sb_if.issue_rd);
        wrd = int'(sb_if.wb_rd);
        iss = sb_if.issue_valid && sb_if.issue_reg_write && ird != 0;
        wbh = sb_if.wb_valid && wrd != 0 && mo[wrd] > 0;
        if (iss && wbh && ird == wrd) begin
            mc[ird] = int'(sb_if.issue_lat);
        end else begin
            if (iss) begin
                mo[ird] = mo[ird] + 1;
                mc[ird] = int'(sb_if.issue_lat);
            end
            if (wbh) begin
                mo[wrd] = mo[wrd] - 1;
                if (mo[wrd] == 0) mc[wrd] = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        sb_if.flush_all = 0; sb_if.freeze = 0;
        sb_if.issue_valid = 0; sb_if.issue_rd = 0; sb_if.issue_reg_write = 0; sb_if.issue_lat = 0;
        sb_if.wb_valid = 0; sb_if.wb_rd = 0;
        sb_if.rs1_addr_id = 0; sb_if.rs1_used = 0; sb_if.rs2_addr_id = 0; sb_if.rs2_used = 0;
        sb_if.rd_addr_id = 0; sb_if.rd_write_id = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
        sb_if.issue_valid = 1; sb_if.issue_reg_write = 1; sb_if.issue_rd = rd; sb_if.issue_lat = lat;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        issue(5'd5, 3'd3);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sb_if.busy_vec !== 32'd0) begin failures++; $display("FAIL reset_busy: got %h expected 0", sb_if.busy_vec); end
        checks++; if (sb_if.stall_id !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", sb_if.stall_id); end
        model_reset();
        @(negedge clk);
        rst = 0;
        step();
        checks++; if (sb_if.busy_vec !== 32'h20) begin failures++; $display("FAIL reset_pre_busy: got %h expected 20", sb_if.busy_vec); end
        sb_if.rs1_addr_id = 5; sb_if.rs1_used = 1;
        #2 rst = 1;
        #1;
        checks++; if (sb_if.busy_vec !== 32'd0) begin failures++; $display("FAIL reset_async_busy: got %h expected 0", sb_if.busy_vec); end
        checks++; if (sb_if.stall_id !== 1'b0) begin failures++; $display("FAIL reset_async_stall: got %b expected 0", sb_if.stall_id); end
        model_reset();
        @(negedge clk);
        rst = 0;
        idle();
        sb_if.rs1_addr_id = 5; sb_if.rs1_used = 1;
        step();
        #1;
        checks++; if (sb_if.rs1_pending !== 1'b0) begin failures++; $display("FAIL reset_rs1_pending: got %b expected 0", sb_if.rs1_pending); end
        checks++; if (sb_if.busy_vec !== 32'd0) begin failures++; $display("FAIL reset_post_busy: got %h expected 0", sb_if.busy_vec); end
    endtask

    task automatic test_load_use();
        idle(); issue(5'd7, 3'd1); step();
        idle(); sb_if.rs1_addr_id = 7; sb_if.rs1_used = 1; #1;
        checks++; if (sb_if.stall_id !== 1'b1) begin failures++; $display("FAIL load_use_stall: got %b expected 1", sb_if.stall_id); end
        step(); #1;
        checks++; if (sb_if.stall_id !== 1'b0) begin failures++; $display("FAIL load_use_release: got %b expected 0", sb_if.stall_id); end
        checks++; if (sb_if.busy_vec[7] !== 1'b1) begin failures++; $display("FAIL load_use_busy: got %b expected 1", sb_if.busy_vec[7]); end
        repeat (2) step();
        checks++; if (sb_if.busy_vec[7] !== 1'b1) begin failures++; $display("FAIL load_use_busy_hold: got %b expected 1", sb_if.busy_vec[7]); end
        sb_if.wb_valid = 1; sb_if.wb_rd = 7; step(); idle(); #1;
        checks++; if (sb_if.busy_vec[7] !== 1'b0) begin failures++; $display("FAIL load_use_wb: got %b expected 0", sb_if.busy_vec[7]); end
    endtask

    task automatic test_multicycle();
        int n = 0;
        idle(); issue(5'd9, 3'd4); step();
        idle(); sb_if.rs2_addr_id = 9; sb_if.rs2_used = 1;
        for (int i = 0; i < 10; i++) begin
            sb_if.freeze = (i < 2);
            #1;
            if (sb_if.stall_id === 1'b1) n++;
            step();
        end
        checks++; if (n != 6) begin failures++; $display("FAIL multicycle_stall_len: got %0d expected 6", n); end
        idle(); issue(5'd9, 3'd4); step();
        idle(); sb_if.rs2_addr_id = 9; sb_if.rs2_used = 0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (sb_if.stall_id !== 1'b0 || sb_if.rs2_pending !== 1'b0) n++;
            step();
        end
        checks++; if (n != 0) begin failures++; $display("FAIL multicycle_unused: got %0d stalls expected 0", n); end
        sb_if.wb_valid = 1; sb_if.wb_rd = 9; repeat (2) step(); idle();
    endtask

    task automatic test_waw();
        int n = 0;
        idle(); issue(5'd3, 3'd2); step();
        idle(); issue(5'd3, 3'd3); sb_if.wb_valid = 1; sb_if.wb_rd = 3; step();
        idle(); sb_if.rs1_addr_id = 3; sb_if.rs1_used = 1;
        checks++; if (sb_if.busy_vec[3] !== 1'b1) begin failures++; $display("FAIL waw_busy: got %b expected 1", sb_if.busy_vec[3]); end
        for (int i = 0; i < 6; i++) begin
            #1;
            if (sb_if.stall_id === 1'b1) n++;
            step();
        end
        checks++; if (n != 3) begin failures++; $display("FAIL waw_stall_len: got %0d expected 3", n); end
        sb_if.wb_valid = 1; sb_if.wb_rd = 3; step(); idle(); #1;
        checks++; if (sb_if.busy_vec[3] !== 1'b0) begin failures++; $display("FAIL waw_clear: got %b expected 0", sb_if.busy_vec[3]); end
    endtask

    task automatic test_x0_saturation();
        idle(); issue(5'd0, 3'd5); step(); idle(); #1;
        checks++; if (sb_if.busy_vec !== 32'd0) begin failures++; $display("FAIL x0_issue: got %h expected 0", sb_if.busy_vec); end
        issue(5'd4, 3'd0); repeat (3) step();
        idle(); sb_if.rd_addr_id = 4; sb_if.rd_write_id = 1; #1;
        checks++; if (sb_if.stall_id !== 1'b1) begin failures++; $display("FAIL sat_stall: got %b expected 1", sb_if.stall_id); end
        sb_if.rd_write_id = 0; #1;
        checks++; if (sb_if.stall_id !== 1'b0) begin failures++; $display("FAIL sat_no_write: got %b expected 0", sb_if.stall_id); end
        sb_if.wb_valid = 1; sb_if.wb_rd = 8; step(); idle(); #1;
        checks++; if (sb_if.busy_vec !== 32'h10) begin failures++; $display("FAIL wb_idle: got %h expected 10", sb_if.busy_vec); end
        sb_if.wb_valid = 1; sb_if.wb_rd = 4; repeat (3) step(); idle(); #1;
        checks++; if (sb_if.busy_vec !== 32'd0) begin failures++; $display("FAIL sat_drain: got %h expected 0", sb_if.busy_vec); end
    endtask

    task automatic test_flush();
        idle(); issue(5'd11, 3'd5); step();
        issue(5'd12, 3'd5); step();
        issue(5'd13, 3'd7); step();
        idle(); sb_if.rs1_addr_id = 11; sb_if.rs1_used = 1; #1;
        checks++; if (sb_if.stall_id !== 1'b1) begin failures++; $display("FAIL flush_pre_stall: got %b expected 1", sb_if.stall_id); end
        sb_if.flush_all = 1; issue(5'd10, 3'd3); step();
        idle(); sb_if.rs1_addr_id = 10; sb_if.rs1_used = 1; sb_if.rs2_addr_id = 11; sb_if.rs2_used = 1; #1;
        checks++; if (sb_if.busy_vec !== 32'd0) begin failures++; $display("FAIL flush_busy: got %h expected 0", sb_if.busy_vec); end
        checks++; if (sb_if.stall_id !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b expected 0", sb_if.stall_id); end
    endtask

    task automatic test_random();
        logic es, e1, e2;
        logic [31:0] eb;
        for (int c = 0; c < 3000; c++) begin
            idle();
            sb_if.rs1_addr_id = 5'($urandom_range(0, 7)); sb_if.rs1_used = 1'($urandom);
            sb_if.rs2_addr_id = 5'($urandom_range(0, 7)); sb_if.rs2_used = 1'($urandom);
            sb_if.rd_addr_id  = 5'($urandom_range(0, 7)); sb_if.rd_write_id = 1'($urandom);
            sb_if.freeze      = ($urandom_range(0, 7) == 0);
            sb_if.flush_all   = ($urandom_range(0, 63) == 0);
            sb_if.wb_valid    = 1'($urandom);
            sb_if.wb_rd       = 5'($urandom_range(0, 7));
            sb_if.issue_rd    = sb_if.rd_addr_id;
            sb_if.issue_reg_write = sb_if.rd_write_id;
            sb_if.issue_lat   = 3'($urandom);
            es = m_stall();
            e1 = m_pend(sb_if.rs1_addr_id, sb_if.rs1_used);
            e2 = m_pend(sb_if.rs2_addr_id, sb_if.rs2_used);
            eb = m_busy();
            sb_if.issue_valid = 1'($urandom) && !es;
            if (sb_if.issue_valid && sb_if.issue_reg_write && sb_if.wb_valid &&
                sb_if.wb_rd == sb_if.issue_rd && mo[sb_if.wb_rd] == 0)
                sb_if.wb_valid = 0;
            #1;
            checks++; if (sb_if.stall_id !== es) begin failures++; $display("FAIL rand_stall c=%0d: got %b expected %b", c, sb_if.stall_id, es); end
            checks++; if (sb_if.rs1_pending !== e1) begin failures++; $display("FAIL rand_rs1 c=%0d: got %b expected %b", c, sb_if.rs1_pending, e1); end
            checks++; if (sb_if.rs2_pending !== e2) begin failures++; $display("FAIL rand_rs2 c=%0d: got %b expected %b", c, sb_if.rs2_pending, e2); end
            checks++; if (sb_if.busy_vec !== eb) begin failures++; $display("FAIL rand_busy c=%0d: got %h expected %h", c, sb_if.busy_vec, eb); end
            if (sb_if.issue_valid && sb_if.issue_reg_write && sb_if.issue_rd != 5'd0 &&
                mo[sb_if.issue_rd] == 3 && !(sb_if.wb_valid && sb_if.wb_rd == sb_if.issue_rd)) begin
                checks++; failures++;
                $display("FAIL rand_issue_saturated c=%0d: rd %0d has 3 outstanding writes", c, sb_if.issue_rd);
            end
            step();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_multicycle();
        test_waw();
        test_x0_saturation();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
